// File: rtl/rect_pixel_scanner_pkg.sv
// Shared definitions for the rectangle pixel scanner: FSM encoding and
// default screen geometry.
package rect_pixel_scanner_pkg;

  // Sweep FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Visible screen size; pixels at or beyond these are clipped.
  localparam int H_MAX_DEF = 160;
  localparam int V_MAX_DEF = 120;

  // Flush counter width; ROM latency is limited to 0..4 clocks.
  localparam int ROM_LAT_MAX = 4;
  localparam int FCNT_W      = 3;

endpackage

// File: rtl/rect_pixel_scanner_delay.sv
// pixel_delay_line: fixed-depth shift register carrying a valid bit and a
// payload. The clear input drops every in-flight valid bit (payload is kept).
// DEPTH=0 degenerates to a wire.
module pixel_delay_line #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ resetn ^ clr_i;
    assign vld_o     = vld_i;
    assign dat_o     = dat_i;
  end else begin : g_pipe
    logic [DEPTH-1:0]            vld_pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe_q;

    // Shift valid and payload one stage per clock; clear kills valids only.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        vld_pipe_q <= '0;
        dat_pipe_q <= '0;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          vld_pipe_q[i] <= vld_pipe_q[i-1] && !clr_i;
          dat_pipe_q[i] <= dat_pipe_q[i-1];
        end
        vld_pipe_q[0] <= vld_i && !clr_i;
        dat_pipe_q[0] <= dat_i;
      end
    end

    assign vld_o = vld_pipe_q[DEPTH-1];
    assign dat_o = dat_pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/rect_pixel_scanner.sv
// rect_pixel_scanner: sweeps a latched rectangle row-major, one pixel per
// clock. addr is the undelayed linear ROM address; x/y/plot come out of a
// ROM_LAT-deep delay line so they line up with the ROM data.
module rect_pixel_scanner
  import rect_pixel_scanner_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15,
  parameter int ROM_LAT = 1,
  parameter int H_MAX   = H_MAX_DEF,
  parameter int V_MAX   = V_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    w,
  input  logic [Y_W-1:0]    h,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  // Clip limits at the widened coordinate width so x0+col carries are seen.
  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_MAX);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_MAX);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [ADDR_W-1:0]   acnt_q, acnt_d, addr_q, addr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                done_q, done_d;
  logic                iss_vld_q, iss_vld_d;
  logic [X_W-1:0]      iss_x_q, iss_x_d;
  logic [Y_W-1:0]      iss_y_q, iss_y_d;

  logic [X_W:0]        xi;
  logic [Y_W:0]        yi;
  logic                in_scan, plot_qual, col_end, last_px, kill;
  logic                dl_vld;
  logic [X_W+Y_W-1:0]  dl_dat;
  logic [X_W-1:0]      xh_q;
  logic [Y_W-1:0]      yh_q;

  // Screen coordinate of the pixel being issued this cycle.
  assign xi        = {1'b0, x0_q} + {1'b0, col_q};
  assign yi        = {1'b0, y0_q} + {1'b0, row_q};
  assign in_scan   = (state_q == S_SCAN);
  assign plot_qual = in_scan && (xi < H_LIM) && (yi < V_LIM);
  assign col_end   = (col_q == w_q - X_W'(1));
  assign last_px   = col_end && (row_q == h_q - Y_W'(1));
  assign kill      = abort && ((state_q == S_SCAN) || (state_q == S_FLUSH));

  // Next-state, counter and issue-stage logic for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    row_d     = row_q;
    acnt_d    = acnt_q;
    addr_d    = addr_q;
    fcnt_d    = fcnt_q;
    done_d    = 1'b0;
    iss_vld_d = 1'b0;
    iss_x_d   = iss_x_q;
    iss_y_d   = iss_y_q;
    case (state_q)
      S_IDLE: begin
        // abort beats start when both arrive in IDLE
        if (start && !abort) begin
          x0_d   = x0;
          y0_d   = y0;
          w_d    = w;
          h_d    = h;
          col_d  = '0;
          row_d  = '0;
          acnt_d = '0;
          state_d = ((w == '0) || (h == '0)) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Clipped pixels still advance addr so ROM stays in step.
          addr_d    = acnt_q;
          iss_vld_d = plot_qual;
          iss_x_d   = xi[X_W-1:0];
          iss_y_d   = yi[Y_W-1:0];
          acnt_d    = acnt_q + ADDR_W'(1);
          if (col_end) begin
            col_d = '0;
            row_d = row_q + Y_W'(1);
          end else begin
            col_d = col_q + X_W'(1);
          end
          if (last_px) begin
            fcnt_d  = '0;
            state_d = (ROM_LAT == 0) ? S_DONE : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fcnt_q == FCNT_W'(ROM_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, rectangle, counters and issue-stage registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      acnt_q    <= '0;
      addr_q    <= '0;
      fcnt_q    <= '0;
      done_q    <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_x_q   <= '0;
      iss_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acnt_q    <= acnt_d;
      addr_q    <= addr_d;
      fcnt_q    <= fcnt_d;
      done_q    <= done_d;
      iss_vld_q <= iss_vld_d;
      iss_x_q   <= iss_x_d;
      iss_y_q   <= iss_y_d;
    end
  end

  pixel_delay_line #(
    .WIDTH (X_W + Y_W),
    .DEPTH (ROM_LAT)
  ) u_dly (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (kill),
    .vld_i  (iss_vld_q),
    .dat_i  ({iss_x_q, iss_y_q}),
    .vld_o  (dl_vld),
    .dat_o  (dl_dat)
  );

  // Remember the last plotted coordinate so x/y hold while plot is low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xh_q <= '0;
      yh_q <= '0;
    end else if (dl_vld) begin
      xh_q <= dl_dat[X_W+Y_W-1:Y_W];
      yh_q <= dl_dat[Y_W-1:0];
    end
  end

  assign addr = addr_q;
  assign plot = dl_vld;
  assign x    = dl_vld ? dl_dat[X_W+Y_W-1:Y_W] : xh_q;
  assign y    = dl_vld ? dl_dat[Y_W-1:0]       : yh_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_rect_pixel_scanner.sv
// Bench for rect_pixel_scanner: three DUTs (ROM_LAT 0, 1, 3) share stimulus
// and are checked every cycle against a timing-formula model.
module tb_rect_pixel_scanner;

  localparam int NL = 3;

  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] x0 = '0, w = '0;
  logic [6:0] y0 = '0, h = '0;

  logic [14:0] addr_l [NL];
  logic [7:0]  x_l    [NL];
  logic [6:0]  y_l    [NL];
  logic        plot_l [NL];
  logic        busy_l [NL];
  logic        done_l [NL];

  rect_pixel_scanner #(.ROM_LAT(0)) u_lat0 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .w(w), .h(h),
    .addr(addr_l[0]), .x(x_l[0]), .y(y_l[0]),
    .plot(plot_l[0]), .busy(busy_l[0]), .done(done_l[0]));

  rect_pixel_scanner #(.ROM_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .w(w), .h(h),
    .addr(addr_l[1]), .x(x_l[1]), .y(y_l[1]),
    .plot(plot_l[1]), .busy(busy_l[1]), .done(done_l[1]));

  rect_pixel_scanner #(.ROM_LAT(3)) u_lat3 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .w(w), .h(h),
    .addr(addr_l[2]), .x(x_l[2]), .y(y_l[2]),
    .plot(plot_l[2]), .busy(busy_l[2]), .done(done_l[2]));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, nprint = 0, start_cyc = 0;
  int pcnt [NL];
  int done_at [NL];

  // Model state: cycles since accepted start (k) and the latched rectangle.
  bit m_act [NL];
  int m_k [NL], m_x0 [NL], m_y0 [NL], m_w [NL], m_h [NL];
  int m_addr [NL], m_xh [NL], m_yh [NL];
  bit e_plot [NL], e_busy [NL], e_done [NL];

  function automatic int lat_of(int l);
    return (l == 0) ? 0 : (l == 1) ? 1 : 3;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    for (int l = 0; l < NL; l++) begin
      int n, lat, dk, p, xi, yi;
      bit idle;
      lat = lat_of(l);
      if (!resetn) begin
        m_act[l] = 0; m_k[l] = 0; m_addr[l] = 0; m_xh[l] = 0; m_yh[l] = 0;
        e_plot[l] = 0; e_busy[l] = 0; e_done[l] = 0;
        continue;
      end
      n  = m_w[l] * m_h[l];
      dk = (n == 0) ? 1 : n + lat + 1;
      idle = !m_act[l] || (m_k[l] == dk);
      if (!idle) begin
        if (abort && n > 0 && m_k[l] <= n + lat - 1) m_act[l] = 0;
        else m_k[l]++;
      end else begin
        m_act[l] = 0;
        if (start && !abort) begin
          m_act[l] = 1; m_k[l] = 0;
          m_x0[l] = int'(x0); m_y0[l] = int'(y0); m_w[l] = int'(w); m_h[l] = int'(h);
        end
      end
      n  = m_w[l] * m_h[l];
      dk = (n == 0) ? 1 : n + lat + 1;
      e_plot[l] = 0;
      if (m_act[l] && n > 0) begin
        if (m_k[l] >= 1 && m_k[l] <= n) m_addr[l] = (m_k[l] - 1) % 32768;
        if (m_k[l] >= lat + 1 && m_k[l] <= n + lat) begin
          p  = m_k[l] - 1 - lat;
          xi = m_x0[l] + p % m_w[l];
          yi = m_y0[l] + p / m_w[l];
          if (xi < 160 && yi < 120) begin
            e_plot[l] = 1; m_xh[l] = xi % 256; m_yh[l] = yi % 128;
          end
        end
      end
      e_busy[l] = m_act[l] && (m_k[l] < dk);
      e_done[l] = m_act[l] && (m_k[l] == dk);
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < NL; l++) begin
      tests++;
      if (addr_l[l] !== 15'(m_addr[l]) || plot_l[l] !== e_plot[l] ||
          x_l[l] !== 8'(m_xh[l]) || y_l[l] !== 7'(m_yh[l]) ||
          busy_l[l] !== e_busy[l] || done_l[l] !== e_done[l]) begin
        fails++;
        if (nprint < 20)
          $display("FAIL model cyc=%0d lat=%0d got addr=%0d plot=%0d x=%0d y=%0d busy=%0d done=%0d want addr=%0d plot=%0d x=%0d y=%0d busy=%0d done=%0d",
                   cyc, lat_of(l), addr_l[l], plot_l[l], x_l[l], y_l[l], busy_l[l], done_l[l],
                   m_addr[l], e_plot[l], m_xh[l], m_yh[l], e_busy[l], e_done[l]);
        nprint++;
      end
      if (plot_l[l] === 1'b1) pcnt[l]++;
      if (done_l[l] === 1'b1) done_at[l] = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic clr_stats();
    for (int l = 0; l < NL; l++) begin pcnt[l] = 0; done_at[l] = -1; end
  endtask

  task automatic go(input int ax0, input int ay0, input int aw, input int ah);
    x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy_l[0] || busy_l[1] || busy_l[2] || done_l[0] || done_l[1] || done_l[2]) && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(n < maxc), 1);
  endtask

  typedef struct {
    bit st;
    int addr;
    bit plot;
    int x;
    int y;
    bit busy;
    bit done;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_stats();
    for (int l = 0; l < NL; l++) begin
      m_act[l] = 0; m_k[l] = 0; m_x0[l] = 0; m_y0[l] = 0; m_w[l] = 0; m_h[l] = 0;
      m_addr[l] = 0; m_xh[l] = 0; m_yh[l] = 0;
    end

    // Reset state (model expects everything zero).
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Basic 3x2 sweep at ROM_LAT=1, expected values written out by hand.
    tbl[0] = '{1, 0, 0,  0,  0, 1, 0};
    tbl[1] = '{0, 0, 0,  0,  0, 1, 0};
    tbl[2] = '{0, 1, 1, 10, 20, 1, 0};
    tbl[3] = '{0, 2, 1, 11, 20, 1, 0};
    tbl[4] = '{0, 3, 1, 12, 20, 1, 0};
    tbl[5] = '{0, 4, 1, 10, 21, 1, 0};
    tbl[6] = '{0, 5, 1, 11, 21, 1, 0};
    tbl[7] = '{0, 5, 1, 12, 21, 1, 0};
    tbl[8] = '{0, 5, 0, 12, 21, 0, 1};
    tbl[9] = '{0, 5, 0, 12, 21, 0, 0};
    x0 = 8'd10; y0 = 7'd20; w = 8'd3; h = 7'd2;
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st;
      tick();
      tests++;
      if (addr_l[1] !== 15'(tbl[i].addr) || plot_l[1] !== tbl[i].plot ||
          x_l[1] !== 8'(tbl[i].x) || y_l[1] !== 7'(tbl[i].y) ||
          busy_l[1] !== tbl[i].busy || done_l[1] !== tbl[i].done) begin
        fails++;
        $display("FAIL table row %0d: got addr=%0d plot=%0d x=%0d y=%0d busy=%0d done=%0d want addr=%0d plot=%0d x=%0d y=%0d busy=%0d done=%0d",
                 i, addr_l[1], plot_l[1], x_l[1], y_l[1], busy_l[1], done_l[1],
                 tbl[i].addr, tbl[i].plot, tbl[i].x, tbl[i].y, tbl[i].busy, tbl[i].done);
      end
    end
    wait_idle(20);

    // Zero-size rectangles: busy one cycle, done the next, no plots.
    clr_stats();
    go(5, 5, 0, 5);
    chk("w0_busy", int'(busy_l[2]), 1);
    tick();
    chk("w0_done", int'(done_l[2]), 1);
    chk("w0_busy_after", int'(busy_l[2]), 0);
    tick();
    go(5, 5, 4, 0);
    tick();
    chk("h0_done", int'(done_l[0]), 1);
    wait_idle(10);
    chk("zero_plots", pcnt[0] + pcnt[1] + pcnt[2], 0);

    // Clipping at the bottom-right corner.
    clr_stats();
    go(158, 119, 4, 2);
    wait_idle(40);
    for (int l = 0; l < NL; l++) begin
      chk("clip_plots", pcnt[l], 2);
      chk("clip_done_cyc", done_at[l] - start_cyc, 8 + lat_of(l) + 1);
    end

    // Mid-sweep abort, then a clean restart.
    clr_stats();
    go(0, 0, 4, 4);
    for (int i = 0; i < 20 && addr_l[1] != 15'd3; i++) tick();
    chk("abort_reach_addr3", int'(addr_l[1]), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_plot", int'(plot_l[1]), 0);
    chk("abort_busy", int'(busy_l[1]), 0);
    repeat (25) tick();
    for (int l = 0; l < NL; l++) chk("abort_no_done", done_at[l], -1);
    clr_stats();
    go(2, 3, 4, 4);
    wait_idle(40);
    for (int l = 0; l < NL; l++) begin
      chk("restart_plots", pcnt[l], 16);
      chk("restart_done_cyc", done_at[l] - start_cyc, 16 + lat_of(l) + 1);
    end

    // Reset during FLUSH, then start pulses while busy are ignored.
    clr_stats();
    go(0, 0, 2, 2);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_busy", int'(busy_l[2]), 0);
    chk("rst_plot", int'(plot_l[2]), 0);
    chk("rst_addr", int'(addr_l[1]), 0);
    repeat (8) tick();
    for (int l = 0; l < NL; l++) chk("rst_no_done", done_at[l], -1);
    clr_stats();
    go(1, 1, 5, 1);
    x0 = 8'd100; w = 8'd7; start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_idle(30);
    for (int l = 0; l < NL; l++) begin
      chk("busy_start_plots", pcnt[l], 5);
      chk("busy_start_lastx", int'(x_l[l]), 5);
    end

    // Full screen sweep.
    clr_stats();
    go(0, 0, 160, 120);
    wait_idle(19300);
    for (int l = 0; l < NL; l++) begin
      chk("full_plots", pcnt[l], 19200);
      chk("full_done_cyc", done_at[l] - start_cyc, 19200 + lat_of(l) + 1);
    end

    // Random traffic near the clip edges with aborts, restarts and resets.
    for (int i = 0; i < 2000; i++) begin
      x0     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 255)) : 8'($urandom);
      y0     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(110, 127)) : 7'($urandom);
      w      = 8'($urandom_range(0, 6));
      h      = 7'($urandom_range(0, 4));
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 24) == 0);
      resetn = ($urandom_range(0, 199) != 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; resetn = 1'b1;
    wait_idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
